// File: rtl/param_data_memory.sv
// param_data_memory: word-organised data memory with a fixed access latency.
//
// A request is accepted in IDLE. It waits WAIT_CYCLES clocks in BUSY, is
// committed on the last of those edges, and is reported with a one-cycle
// ready pulse from DONE.
//
// Parameters
//   WORD_LEN     data word width in bits (multiple of 8)
//   ADDRESS_LEN  byte-address width
//   DEPTH        number of words stored
//   BASE_ADDR    byte address of word 0 (word aligned)
//   WAIT_CYCLES  access latency in clocks (>= 1)
//
// Ports
//   clk       clock, all state changes on the rising edge
//   rst       synchronous active-high reset (memory contents are kept)
//   MEM_R_EN  read request
//   MEM_W_EN  write request (wins over MEM_R_EN when both are set)
//   ALU_Res   byte address
//   Val_RM    write data
//   byte_en   per-byte write enables, bit i covers bits [8i+7:8i]
//   out       registered read data (post-write word on writes, 0 on error)
//   ready     one-cycle completion pulse
//   addr_err  address error flag, meaningful while ready is high
module param_data_memory #(
    parameter int unsigned WORD_LEN    = 32,
    parameter int unsigned ADDRESS_LEN = 32,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    MEM_R_EN,
    input  logic                    MEM_W_EN,
    input  logic [ADDRESS_LEN-1:0]  ALU_Res,
    input  logic [WORD_LEN-1:0]     Val_RM,
    input  logic [WORD_LEN/8-1:0]   byte_en,
    output logic [WORD_LEN-1:0]     out,
    output logic                    ready,
    output logic                    addr_err
);

    localparam int unsigned ByteW = WORD_LEN / 8;
    localparam int unsigned IdxW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CntW-1:0]        CntLoad = CntW'(WAIT_CYCLES - 1);
    localparam logic [ADDRESS_LEN-1:0] BaseA   = ADDRESS_LEN'(BASE_ADDR);
    localparam logic [ADDRESS_LEN-1:0] DepthA  = ADDRESS_LEN'(DEPTH);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                   state_q, state_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [ADDRESS_LEN-1:0]   addr_q, addr_d;
    logic [WORD_LEN-1:0]      wdata_q, wdata_d;
    logic [ByteW-1:0]         be_q, be_d;
    logic                     we_q, we_d;
    logic [WORD_LEN-1:0]      out_q, out_d;
    logic                     err_q, err_d;

    logic [WORD_LEN-1:0]      mem_q [DEPTH];

    logic [ADDRESS_LEN-1:0]   offset;
    logic [ADDRESS_LEN-1:0]   word_idx;
    logic [IdxW-1:0]          idx;
    logic                     addr_ok;
    logic [WORD_LEN-1:0]      rd_word;
    logic [WORD_LEN-1:0]      merged;
    logic                     commit;
    logic                     mem_we;

    // Range check is done on the word index rather than on BASE_ADDR + 4*DEPTH
    // so that the upper bound cannot overflow ADDRESS_LEN.
    always_comb begin
        offset   = addr_q - BaseA;
        word_idx = offset >> 2;
        addr_ok  = (addr_q[1:0] == 2'b00) && (addr_q >= BaseA) && (word_idx < DepthA);
        idx      = word_idx[IdxW-1:0];
        rd_word  = mem_q[idx];
        merged   = rd_word;
        for (int unsigned i = 0; i < ByteW; i++) begin
            if (be_q[i]) begin
                merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    assign commit = (state_q == StBusy) && (cnt_q == '0);
    assign mem_we = commit && we_q && addr_ok;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        we_d    = we_q;
        out_d   = out_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (MEM_R_EN || MEM_W_EN) begin
                    addr_d  = ALU_Res;
                    wdata_d = Val_RM;
                    be_d    = byte_en;
                    we_d    = MEM_W_EN;
                    cnt_d   = CntLoad;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = StDone;
                    err_d   = !addr_ok;
                    if (!addr_ok) begin
                        out_d = '0;
                    end else if (we_q) begin
                        out_d = merged;
                    end else begin
                        out_d = rd_word;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
        end
    end

    // Array has no reset; rst only blocks a commit that coincides with it.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[idx] <= merged;
        end
    end

    assign out      = out_q;
    assign addr_err = err_q;
    assign ready    = (state_q == StDone);

endmodule

// File: tb/tb_param_data_memory.sv
// Scoreboard bench for param_data_memory: two instances (latency 2 and 1).
module tb_param_data_memory;

    localparam time P = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        r0, w0, r1, w1;
    logic [31:0] a0, d0, a1, d1;
    logic [3:0]  b0, b1;
    logic [31:0] out0, out1;
    logic        rdy0, rdy1, err0, err1;

    param_data_memory #(.WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .rst(rst), .MEM_R_EN(r0), .MEM_W_EN(w0), .ALU_Res(a0), .Val_RM(d0),
        .byte_en(b0), .out(out0), .ready(rdy0), .addr_err(err0)
    );

    param_data_memory #(.WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .MEM_R_EN(r1), .MEM_W_EN(w1), .ALU_Res(a1), .Val_RM(d1),
        .byte_en(b1), .out(out1), .ready(rdy1), .addr_err(err1)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        time         acc;
        int unsigned lat;
        string       name;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic compare(input exp_t x, input logic [31:0] o, input logic e);
        check($sformatf("%s data", x.name), o, x.data);
        check($sformatf("%s addr_err", x.name), 32'(e), 32'(x.err));
        check($sformatf("%s latency", x.name), 32'(($time - P / 2 - x.acc) / P), 32'(x.lat));
    endtask

    // Monitors: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rdy0 === 1'b1) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut0 unexpected ready: got 1 expected 0");
            end else begin
                compare(q0.pop_front(), out0, err0);
            end
        end
    end

    always @(negedge clk) begin
        if (rdy1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1 unexpected ready: got 1 expected 0");
            end else begin
                compare(q1.pop_front(), out1, err1);
            end
        end
    end

    task automatic wait_rdy(input int id, input int n, input string name);
        int seen = 0;
        for (int i = 0; i < 60 && seen < n; i++) begin
            @(negedge clk);
            if ((id == 0 ? rdy0 : rdy1) === 1'b1) seen++;
        end
        if (seen < n) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got %0d ready pulses expected %0d", name, seen, n);
        end
    endtask

    task automatic req0(input string name, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b, input logic [31:0] eo,
                        input logic ee);
        exp_t x;
        @(negedge clk);
        r0 = r; w0 = w; a0 = a; d0 = d; b0 = b;
        @(posedge clk);
        x.data = eo; x.err = ee; x.acc = $time; x.lat = 2; x.name = name;
        q0.push_back(x);
        #1;
        // Scramble the inputs while the access is in flight.
        r0 = 1'b0; w0 = 1'b0; a0 = ~a; d0 = ~d; b0 = ~b;
        wait_rdy(0, 1, name);
    endtask

    task automatic req1(input string name, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] eo);
        exp_t x;
        @(negedge clk);
        w1 = 1'b1; a1 = a; d1 = d; b1 = 4'hF;
        @(posedge clk);
        x.data = eo; x.err = 1'b0; x.acc = $time; x.lat = 1; x.name = name;
        q1.push_back(x);
        #1;
        w1 = 1'b0;
        wait_rdy(1, 1, name);
    endtask

    initial begin
        exp_t x;
        time  t0;
        rst = 1'b1;
        r0 = 0; w0 = 0; a0 = 0; d0 = 0; b0 = 0;
        r1 = 0; w1 = 0; a1 = 0; d1 = 0; b1 = 0;
        repeat (3) @(negedge clk);
        check("reset out", out0, 32'h0);
        check("reset ready", 32'(rdy0), 32'h0);
        check("reset addr_err", 32'(err0), 32'h0);
        check("reset ready dut1", 32'(rdy1), 32'h0);
        rst = 1'b0;

        req0("wr 1028", 0, 1, 1028, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 0);
        req0("rd 1028", 1, 0, 1028, 32'h0, 4'h0, 32'hDEADBEEF, 0);
        req0("wr 1024 full", 0, 1, 1024, 32'h11223344, 4'hF, 32'h11223344, 0);
        req0("wr 1024 partial", 0, 1, 1024, 32'hAABBCCDD, 4'b0101, 32'h11BB33DD, 0);
        req0("rd 1024", 1, 0, 1024, 32'h0, 4'h0, 32'h11BB33DD, 0);
        req0("rd 1020", 1, 0, 1020, 32'h0, 4'h0, 32'h0, 1);
        req0("rd 1026", 1, 0, 1026, 32'h0, 4'h0, 32'h0, 1);
        req0("wr 1280", 0, 1, 1280, 32'hCAFEF00D, 4'hF, 32'h0, 1);
        req0("rd 1024 after err", 1, 0, 1024, 32'h0, 4'h0, 32'h11BB33DD, 0);
        req0("rd 1028 after err", 1, 0, 1028, 32'h0, 4'h0, 32'hDEADBEEF, 0);
        req0("rd+wr 1032", 1, 1, 1032, 32'h5, 4'hF, 32'h5, 0);
        req0("rd 1032", 1, 0, 1032, 32'h0, 4'h0, 32'h5, 0);
        req0("wr 1036 old", 0, 1, 1036, 32'h55, 4'hF, 32'h55, 0);

        // Write aborted by reset one edge after acceptance.
        @(negedge clk);
        w0 = 1'b1; a0 = 1036; d0 = 32'h7; b0 = 4'hF;
        @(posedge clk);
        #1 w0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort out cleared", out0, 32'h0);
        check("abort addr_err", 32'(err0), 32'h0);
        check("abort ready", 32'(rdy0), 32'h0);
        repeat (6) @(negedge clk);
        req0("rd 1036 after abort", 1, 0, 1036, 32'h0, 4'h0, 32'h55, 0);

        // Back-to-back reads with MEM_R_EN held high: accepts every WAIT_CYCLES+2 edges.
        @(negedge clk);
        r0 = 1'b1; a0 = 1028; w0 = 1'b0;
        @(posedge clk);
        t0 = $time;
        for (int k = 0; k < 3; k++) begin
            x.data = 32'hDEADBEEF; x.err = 1'b0; x.acc = t0 + k * 4 * P; x.lat = 2;
            x.name = $sformatf("stream0 #%0d", k);
            q0.push_back(x);
        end
        wait_rdy(0, 3, "stream0");
        r0 = 1'b0;
        repeat (8) @(negedge clk);

        // Same with latency 1.
        req1("dut1 wr 1028", 1028, 32'h12345678, 32'h12345678);
        @(negedge clk);
        r1 = 1'b1; a1 = 1028;
        @(posedge clk);
        t0 = $time;
        for (int k = 0; k < 3; k++) begin
            x.data = 32'h12345678; x.err = 1'b0; x.acc = t0 + k * 3 * P; x.lat = 1;
            x.name = $sformatf("stream1 #%0d", k);
            q1.push_back(x);
        end
        wait_rdy(1, 3, "stream1");
        r1 = 1'b0;
        repeat (8) @(negedge clk);

        check("dut0 outstanding", 32'(q0.size()), 32'h0);
        check("dut1 outstanding", 32'(q1.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
